// File: rtl/zdrode_pkg.sv
// zdrode_pkg: shared sizing and frame slicing for the sample frame deserializer
package zdrode_pkg;
  localparam int NUM_UNITS = 4;
  localparam int DATA_WIDTH = 16;
  localparam int CH_IDX_W = $clog2(NUM_UNITS);
  localparam int BYTE_W = 8;
  localparam int FRAME_W = NUM_UNITS * DATA_WIDTH;
  function automatic int slice_lo(input int k);
    return k * DATA_WIDTH;
  endfunction
endpackage

// File: rtl/sample_frame_deserializer_edge.sv
// strobe_edge_detect: registers a level strobe and flags its rising edge once
module strobe_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic strb_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) strb_q <= 1'b0;
    else strb_q <= level;
  assign rise = level & ~strb_q;
endmodule

// File: rtl/sample_frame_deserializer.sv
// sample_frame_deserializer: assembles MSB-first byte pairs into channel samples and publishes full frames
module sample_frame_deserializer #(
  parameter int NUM_UNITS = zdrode_pkg::NUM_UNITS,
  parameter int DATA_WIDTH = zdrode_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [zdrode_pkg::BYTE_W-1:0]    byte_i,
  input  logic                             wr_strb_i,
  input  logic                             resync_i,
  input  logic                             clr_err_i,
  output logic                             ch_valid_o,
  output logic [$clog2(NUM_UNITS)-1:0]     ch_idx_o,
  output logic [DATA_WIDTH-1:0]            ch_sample_o,
  output logic                             frame_valid_o,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]  frame_o,
  output logic                             busy_o,
  output logic                             err_o
);
  import zdrode_pkg::*;
  localparam int CW = $clog2(NUM_UNITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic rise, phase, last, tmo;
  logic [CW-1:0] ch;
  logic [TW-1:0] tcnt;
  logic [NUM_UNITS*DATA_WIDTH-1:0] shadow, shadow_lo;
  int lo;
  strobe_edge_detect u_edge (.clk(clk), .rst(rst), .level(wr_strb_i), .rise(rise));
  // shadow_lo is the shadow as it will look once the current low byte lands
  always_comb begin
    lo = slice_lo(int'(ch));
    shadow_lo = shadow;
    shadow_lo[lo +: BYTE_W] = byte_i;
  end
  assign busy_o = (ch != '0) | phase;
  assign last = ch == CW'(NUM_UNITS - 1);
  assign tmo = busy_o & ~rise & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ch_valid_o <= 1'b0;
      ch_idx_o <= '0;
      ch_sample_o <= '0;
      frame_valid_o <= 1'b0;
      frame_o <= '0;
      err_o <= 1'b0;
      phase <= 1'b0;
      ch <= '0;
      tcnt <= '0;
      shadow <= '0;
    end else begin
      ch_valid_o <= 1'b0;
      frame_valid_o <= 1'b0;
      err_o <= (tmo & ~resync_i) | (err_o & ~clr_err_i);
      if (resync_i | tmo) begin
        ch <= '0;
        phase <= 1'b0;
        tcnt <= '0;
      end else if (rise) begin
        tcnt <= '0;
        phase <= ~phase;
        if (!phase) shadow[lo+BYTE_W +: BYTE_W] <= byte_i;
        else begin
          shadow <= shadow_lo;
          ch_valid_o <= 1'b1;
          ch_idx_o <= ch;
          ch_sample_o <= shadow_lo[lo +: DATA_WIDTH];
          ch <= last ? '0 : ch + 1'b1;
          if (last) begin
            frame_o <= shadow_lo;
            frame_valid_o <= 1'b1;
          end
        end
      end else if (busy_o) tcnt <= tcnt + 1'b1;
    end
endmodule

// File: tb/tb_sample_frame_deserializer.sv
// tb_sample_frame_deserializer: random and directed stimulus against a byte-queue reference model
module tb_sample_frame_deserializer;
  localparam int N = 4;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] byte_i = '0;
  logic wr_strb_i = 1'b0, resync_i = 1'b0, clr_err_i = 1'b0;
  logic ch_valid_o, frame_valid_o, busy_o, err_o;
  logic [1:0] ch_idx_o;
  logic [15:0] ch_sample_o;
  logic [63:0] frame_o;
  sample_frame_deserializer dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .wr_strb_i(wr_strb_i), .resync_i(resync_i),
    .clr_err_i(clr_err_i), .ch_valid_o(ch_valid_o), .ch_idx_o(ch_idx_o), .ch_sample_o(ch_sample_o),
    .frame_valid_o(frame_valid_o), .frame_o(frame_o), .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc_n = 0, fv_cnt = 0;
  int fv_times[$];
  logic [17:0] log_q[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // reference model: bytes of the frame in progress, idle count, expected registered outputs
  logic [7:0] q[$];
  logic m_prev = 1'b0, m_e, m_tmo, m_err = 1'b0, e_chv = 1'b0, e_fv = 1'b0;
  logic [1:0] e_idx = '0;
  logic [15:0] e_smp = '0;
  logic [63:0] e_frame = '0;
  int m_idle = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_prev = 0; m_idle = 0; m_err = 0; e_chv = 0; e_fv = 0; e_frame = '0;
    end else begin
      m_e = wr_strb_i && !m_prev;
      m_prev = wr_strb_i;
      m_tmo = 0; e_chv = 0; e_fv = 0;
      if (resync_i) begin
        q.delete(); m_idle = 0;
      end else if (m_e) begin
        m_idle = 0;
        q.push_back(byte_i);
        if (q.size() % 2 == 0) begin
          e_chv = 1;
          e_idx = 2'(q.size() / 2 - 1);
          e_smp = {q[q.size()-2], q[q.size()-1]};
        end
        if (q.size() == 2 * N) begin
          for (int k = 0; k < N; k++) e_frame[k*16 +: 16] = {q[2*k], q[2*k+1]};
          e_fv = 1;
          q.delete();
        end
      end else if (q.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          q.delete(); m_idle = 0; m_tmo = 1;
        end
      end
      m_err = m_tmo ? 1'b1 : clr_err_i ? 1'b0 : m_err;
    end
  end
  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      chk("rst_frame", frame_o, 64'h0);
      chk("rst_ctl", 64'({ch_valid_o, ch_idx_o, ch_sample_o, frame_valid_o, busy_o, err_o}), 64'h0);
    end else begin
      chk("ch_valid", 64'(ch_valid_o), 64'(e_chv));
      if (e_chv) chk("ch_data", 64'({ch_idx_o, ch_sample_o}), 64'({e_idx, e_smp}));
      chk("frame_valid", 64'(frame_valid_o), 64'(e_fv));
      chk("frame", frame_o, e_frame);
      chk("busy", 64'(busy_o), 64'(q.size() != 0));
      chk("err", 64'(err_o), 64'(m_err));
      if (ch_valid_o) log_q.push_back({ch_idx_o, ch_sample_o});
      if (frame_valid_o) begin
        fv_cnt++;
        fv_times.push_back(cyc_n);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(input logic [7:0] b, input int hold = 1, input int gap = 1, input logic rs = 1'b0);
    byte_i = b; wr_strb_i = 1'b1; resync_i = rs;
    tick(1);
    resync_i = 1'b0;
    tick(hold - 1);
    wr_strb_i = 1'b0;
    tick(gap);
  endtask
  task automatic send_frame(input logic [63:0] f, input int hold = 1);
    for (int k = 0; k < N; k++) begin
      send(f[k*16+8 +: 8], hold);
      send(f[k*16 +: 8], hold);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int fv0, t0, r;
    tick(3); rst = 0; tick(2);
    log_q.delete();
    send_frame(64'hFFFF_0001_ABCD_1234);
    chk("basic_fv_cnt", 64'(fv_cnt), 64'd1);
    chk("basic_nsamp", 64'(log_q.size()), 64'd4);
    chk("basic_s0", 64'(log_q[0]), 64'h0_1234);
    chk("basic_s1", 64'(log_q[1]), 64'h1_ABCD);
    chk("basic_s2", 64'(log_q[2]), 64'h2_0001);
    chk("basic_s3", 64'(log_q[3]), 64'h3_FFFF);
    chk("basic_frame", frame_o, 64'hFFFF_0001_ABCD_1234);
    log_q.delete();
    send_frame(64'hFFFF_0001_ABCD_1234, 5);
    chk("held_fv_cnt", 64'(fv_cnt), 64'd2);
    chk("held_nsamp", 64'(log_q.size()), 64'd4);
    chk("held_s1", 64'(log_q[1]), 64'h1_ABCD);
    chk("held_frame", frame_o, 64'hFFFF_0001_ABCD_1234);
    send(8'h11); send(8'h22); send(8'h33);
    tick(70);
    chk("tmo_err", 64'(err_o), 64'd1);
    chk("tmo_busy", 64'(busy_o), 64'd0);
    chk("tmo_frame", frame_o, 64'hFFFF_0001_ABCD_1234);
    send_frame(64'h0403_0201_BEEF_CAFE);
    chk("after_tmo_frame", frame_o, 64'h0403_0201_BEEF_CAFE);
    clr_err_i = 1; tick(1); clr_err_i = 0;
    chk("clr_err", 64'(err_o), 64'd0);
    send(8'h55); send(8'h56); send(8'h57); send(8'h58);
    send(8'h99, 1, 1, 1'b1);
    send_frame(64'h1111_2222_3333_4444);
    chk("resync_frame", frame_o, 64'h1111_2222_3333_4444);
    chk("resync_err", 64'(err_o), 64'd0);
    fv0 = fv_cnt;
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i));
    rst = 1; #1;
    chk("mid_rst_frame", frame_o, 64'h0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    tick(2); rst = 0; tick(1);
    chk("mid_rst_no_fv", 64'(fv_cnt), 64'(fv0));
    send_frame(64'hDEAD_BEEF_0BAD_F00D);
    chk("post_rst_frame", frame_o, 64'hDEAD_BEEF_0BAD_F00D);
    t0 = fv_times.size();
    send_frame(64'h0102_0304_0506_0708);
    chk("b2b_frame1", frame_o, 64'h0102_0304_0506_0708);
    send_frame(64'h8877_6655_4433_2211);
    chk("b2b_count", 64'(fv_times.size() - t0), 64'd2);
    if (fv_times.size() - t0 == 2) chk("b2b_spacing", 64'(fv_times[t0+1] - fv_times[t0]), 64'd16);
    chk("b2b_frame2", frame_o, 64'h8877_6655_4433_2211);
    repeat (600) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin resync_i = 1; tick(1); resync_i = 0; end
      else if (r < 5) begin clr_err_i = 1; tick(1); clr_err_i = 0; end
      else if (r < 7) tick($urandom_range(60, 70));
      else send(8'($urandom), $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 49) == 0);
    end
    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
